// File: rtl/md5_search_ctrl.sv
// Brute-force preimage search sequencer feeding one pipelined md5core; optional MD5_SEARCH_TRIED_COUNT_EN adds a hash-compare counter.
// Latency: one candidate per clock from the cycle after an accepted start; result PIPE_LATENCY+1 clocks after the matching issue.
// Backpressure: none; md5core accepts every cycle, start is ignored while busy and abort always wins.
module md5_search_ctrl #(
  parameter int unsigned PIPE_LATENCY = 64,
  parameter logic [7:0]  CHAR_LO      = 8'h61,
  parameter logic [7:0]  CHAR_HI      = 8'h7A
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [127:0] target_hash,
  input  logic [3:0]   min_len,
  input  logic [3:0]   max_len,
  output logic [63:0]  core_message,
  output logic [63:0]  core_length,
  input  logic [127:0] core_hash,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         err,
  output logic [63:0]  found_msg,
  output logic [3:0]   found_len,
  output logic [63:0]  tried_count
);

  localparam int LAT = int'(PIPE_LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [63:0]   msg_q, msg_d;
  logic [3:0]    len_q, len_d;
  logic          pres_vld_q, pres_vld_d;
  logic [3:0]    max_len_q, max_len_d;
  logic [127:0]  target_q, target_d;
  logic          found_q, found_d;
  logic          err_q, err_d;
  logic [63:0]   found_msg_q, found_msg_d;
  logic [3:0]    found_len_q, found_len_d;

  // Tracking line: one entry per in-flight core slot, tail aligns with core_hash.
  logic [LAT-1:0] trk_vld_q;
  logic [63:0]    trk_msg_q [LAT];
  logic [3:0]     trk_len_q [LAT];
  logic           trk_clr;

  logic          cmp_en;
  logic          tail_vld;
  logic          hit;
  logic          others_vld;
  logic          cfg_bad;
  logic [63:0]   odo_msg;
  logic          odo_carry;

  // A candidate of n characters, every character at the low end of the range.
  function automatic logic [63:0] all_lo(input logic [3:0] n);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < n) m[8*i +: 8] = CHAR_LO;
    end
    return m;
  endfunction

  assign cfg_bad = (min_len == 4'd0) || (max_len > 4'd8) || (min_len > max_len);
  assign cmp_en  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign tail_vld = trk_vld_q[LAT-1];
  assign hit     = cmp_en && tail_vld && (core_hash == target_q);

  // Odometer step: last char is the least significant digit; carry out means the length is exhausted.
  always_comb begin
    odo_msg   = msg_q;
    odo_carry = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (odo_carry && (4'(i) < len_q)) begin
        if (msg_q[8*i +: 8] == CHAR_HI) begin
          odo_msg[8*i +: 8] = CHAR_LO;
        end else begin
          odo_msg[8*i +: 8] = msg_q[8*i +: 8] + 8'd1;
          odo_carry         = 1'b0;
        end
      end
    end
  end

  // Any valid entry still ahead of the tail means the drain is not finished.
  always_comb begin
    others_vld = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      others_vld = others_vld | trk_vld_q[i];
    end
  end

  // Next-state and datapath updates; abort overrides everything, a match overrides issuing.
  always_comb begin
    state_d     = state_q;
    msg_d       = msg_q;
    len_d       = len_q;
    pres_vld_d  = pres_vld_q;
    max_len_d   = max_len_q;
    target_d    = target_q;
    found_d     = found_q;
    err_d       = err_q;
    found_msg_d = found_msg_q;
    found_len_d = found_len_q;
    trk_clr     = 1'b0;

    if (abort) begin
      state_d    = ST_IDLE;
      pres_vld_d = 1'b0;
      found_d    = 1'b0;
      err_d      = 1'b0;
      trk_clr    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            // Stale entries from an earlier search must never compare against the new target.
            trk_clr     = 1'b1;
            found_d     = 1'b0;
            err_d       = 1'b0;
            found_msg_d = '0;
            found_len_d = '0;
            if (cfg_bad) begin
              state_d = ST_DONE;
              err_d   = 1'b1;
            end else begin
              target_d   = target_hash;
              max_len_d  = max_len;
              msg_d      = all_lo(min_len);
              len_d      = min_len;
              pres_vld_d = 1'b1;
              state_d    = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (hit) begin
            state_d     = ST_DONE;
            found_d     = 1'b1;
            found_msg_d = trk_msg_q[LAT-1];
            found_len_d = trk_len_q[LAT-1];
            pres_vld_d  = 1'b0;
          end else if (!odo_carry) begin
            msg_d      = odo_msg;
            pres_vld_d = 1'b1;
          end else if (len_q < max_len_q) begin
            len_d      = len_q + 4'd1;
            msg_d      = all_lo(len_q + 4'd1);
            pres_vld_d = 1'b1;
          end else begin
            // The candidate on the bus now is the final one; it is already tagged valid.
            state_d    = ST_DRAIN;
            pres_vld_d = 1'b0;
          end
        end
        ST_DRAIN: begin
          if (hit) begin
            state_d     = ST_DONE;
            found_d     = 1'b1;
            found_msg_d = trk_msg_q[LAT-1];
            found_len_d = trk_len_q[LAT-1];
          end else if (!others_vld && !pres_vld_q) begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      msg_q       <= '0;
      len_q       <= '0;
      pres_vld_q  <= 1'b0;
      max_len_q   <= '0;
      target_q    <= '0;
      found_q     <= 1'b0;
      err_q       <= 1'b0;
      found_msg_q <= '0;
      found_len_q <= '0;
    end else begin
      state_q     <= state_d;
      msg_q       <= msg_d;
      len_q       <= len_d;
      pres_vld_q  <= pres_vld_d;
      max_len_q   <= max_len_d;
      target_q    <= target_d;
      found_q     <= found_d;
      err_q       <= err_d;
      found_msg_q <= found_msg_d;
      found_len_q <= found_len_d;
    end
  end

  // Valid bits shift every cycle; only they need clearing, the payload is qualified by them.
  always_ff @(posedge clk) begin
    if (!rst_n || trk_clr) begin
      trk_vld_q <= '0;
    end else begin
      trk_vld_q[0] <= pres_vld_q;
      for (int i = 1; i < LAT; i++) begin
        trk_vld_q[i] <= trk_vld_q[i-1];
      end
    end
  end

  // Payload shift tracks exactly what is presented to the core.
  always_ff @(posedge clk) begin
    trk_msg_q[0] <= msg_q;
    trk_len_q[0] <= len_q;
    for (int i = 1; i < LAT; i++) begin
      trk_msg_q[i] <= trk_msg_q[i-1];
      trk_len_q[i] <= trk_len_q[i-1];
    end
  end

`ifdef MD5_SEARCH_TRIED_COUNT_EN
  logic [63:0] tried_q, tried_d;

  // Count every valid compare, including the matching one; saturate rather than wrap.
  always_comb begin
    tried_d = tried_q;
    if (trk_clr) begin
      tried_d = '0;
    end else if (cmp_en && tail_vld && (tried_q != '1)) begin
      tried_d = tried_q + 64'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) tried_q <= '0;
    else        tried_q <= tried_d;
  end

  assign tried_count = tried_q;
`else
  assign tried_count = '0;
`endif

  assign core_message = msg_q;
  assign core_length  = {57'd0, len_q, 3'd0};
  assign busy         = cmp_en;
  assign done         = (state_q == ST_DONE);
  assign found        = found_q;
  assign err          = err_q;
  assign found_msg    = found_msg_q;
  assign found_len    = found_len_q;

endmodule
